// File: rtl/clock_div_pkg.sv
// clock_div_pkg: shared FSM state, reset period and period legalization.
// Defining CLOCK_DIV_GEN_ODD_EN keeps odd periods instead of rounding them up.
package clock_div_pkg;
  typedef enum logic [1:0] {STOP, HIGH, LOW} divState;
  localparam int unsigned DEFAULT_RESET_PERIOD = 2;
  function automatic logic [31:0] legalize_period(input logic [31:0] p, input int unsigned width);
    logic [31:0] maxVal;
    maxVal = 32'hFFFF_FFFF >> (32 - width);
    if (p < 32'd2) return 32'd2;
`ifndef CLOCK_DIV_GEN_ODD_EN
    if (p[0]) return (p == maxVal) ? p - 32'd1 : p + 32'd1;
`endif
    return p;
  endfunction
endpackage

// File: rtl/clock_div_phase_ctr.sv
// clock_div_phase_ctr: loadable phase down-counter; last is high in the final cycle of a phase.
module clock_div_phase_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             loadHigh,
  input  logic             loadLow,
  input  logic [WIDTH-1:0] highLen,
  input  logic [WIDTH-1:0] lowLen,
  output logic             last
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clock) begin
    if (reset) count <= '0;
    else if (loadHigh) count <= highLen - WIDTH'(1);
    else if (loadLow) count <= lowLen - WIDTH'(1);
    else if (count != '0) count <= count - WIDTH'(1);
  end
  assign last = count == '0;
endmodule

// File: rtl/clock_div_gen.sv
// clock_div_gen: programmable glitch-free clock divider with period handshake.
// Odd periods are honoured only when CLOCK_DIV_GEN_ODD_EN is defined.
module clock_div_gen
  import clock_div_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int RESET_PERIOD = DEFAULT_RESET_PERIOD
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             period_valid,
  output logic             period_ready,
  input  logic [WIDTH-1:0] period_bits,
  output logic             clock_out,
  output logic             active,
  output logic             rise
);
  localparam logic [WIDTH-1:0] RESET_LEGAL = WIDTH'(legalize_period(32'(RESET_PERIOD), WIDTH));
  divState state;
  logic [WIDTH-1:0] curPeriod, pending, nextPeriod, legalBits, highLen, lowLen;
  logic pendValid, last, startHigh, startLow;
  assign legalBits = WIDTH'(legalize_period(32'(period_bits), WIDTH));
  // a period starting this edge takes the pending value if one is waiting
  assign nextPeriod = pendValid ? pending : curPeriod;
`ifdef CLOCK_DIV_GEN_ODD_EN
  assign highLen = (nextPeriod >> 1) + WIDTH'(nextPeriod[0]);
`else
  assign highLen = nextPeriod >> 1;
`endif
  assign lowLen = curPeriod >> 1;
  assign period_ready = !pendValid;
  assign startHigh = enable && (state == STOP || (state == LOW && last));
  assign startLow = state == HIGH && last;
  clock_div_phase_ctr #(.WIDTH(WIDTH)) phaseCtr (
    .clock(clock),
    .reset(reset),
    .loadHigh(startHigh),
    .loadLow(startLow),
    .highLen(highLen),
    .lowLen(lowLen),
    .last(last)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= STOP;
      clock_out <= 1'b0;
      active <= 1'b0;
      rise <= 1'b0;
      pendValid <= 1'b0;
      pending <= '0;
      curPeriod <= RESET_LEGAL;
    end else begin
      rise <= startHigh;
      if (period_valid && !pendValid) begin
        pending <= legalBits;
        pendValid <= 1'b1;
      end
      if (startHigh) begin
        state <= HIGH;
        clock_out <= 1'b1;
        active <= 1'b1;
        if (pendValid) begin
          curPeriod <= pending;
          pendValid <= 1'b0;
        end
      end else if (startLow) begin
        state <= LOW;
        clock_out <= 1'b0;
      end else if (state == LOW && last) begin
        state <= STOP;
        active <= 1'b0;
      end
    end
  end
endmodule
